// File: rtl/led_pkg.sv
// Shared types and reset defaults for the multi-channel LED controller.
package led_pkg;

   // Channel operating mode. The encoding matches the wr_mode_i field.
   typedef enum logic [1:0] {
      LED_OFF   = 2'd0,
      LED_ON    = 2'd1,
      LED_BLINK = 2'd2,
      LED_PWM   = 2'd3
   } led_mode_e;

   // Config fields are carried at a fixed maximum width. Narrower instances
   // zero-extend into them, so DIVW must be <= 8 and PWMW must be <= 16.
   localparam int LED_DIV_MAXW  = 8;
   localparam int LED_DUTY_MAXW = 16;

   typedef struct packed {
      led_mode_e                 mode;
      logic [LED_DIV_MAXW-1:0]   div;
      logic [LED_DUTY_MAXW-1:0]  duty;
   } led_cfg_t;

   // Mode and prescale exponent that every channel starts with after reset.
   localparam led_mode_e LED_RST_MODE = LED_BLINK;
   localparam int        LED_RST_DIV  = 24;

endpackage

// File: rtl/led_chan.sv
// One LED channel: power-of-two prescaler that drives a blink or PWM output.
module led_chan
   import led_pkg::*;
#(
   parameter int        CNTW     = 32,
   parameter int        PWMW     = 8,
   parameter led_mode_e RST_MODE = LED_RST_MODE,
   parameter int        RST_DIV  = LED_RST_DIV
)(
   input  logic     clk100,
   input  logic     rst,
   input  logic     load,
   input  led_cfg_t cfg_in,
   output logic     led,
   output logic     tick
);

   localparam led_cfg_t RST_CFG = '{mode: RST_MODE,
                                    div:  LED_DIV_MAXW'(RST_DIV),
                                    duty: '0};

   led_cfg_t          cfg;
   logic [CNTW-1:0]   cnt;
   logic [CNTW-1:0]   term;
   logic [PWMW-1:0]   phase;
   logic [PWMW-1:0]   phase_nxt;
   logic              blink;
   logic              blink_nxt;
   logic              wrap;
   logic              led_nxt;

   // Terminal count 2**d - 1. The exponent saturates at CNTW-1 so the
   // counter can always reach it.
   function automatic logic [CNTW-1:0] term_of(input logic [LED_DIV_MAXW-1:0] d);
      int e;
      e = int'(d);
      if (e > CNTW - 1) e = CNTW - 1;
      return (CNTW'(1) << e) - CNTW'(1);
   endfunction

   // LED level for a mode, given the blink flop and the PWM phase that will
   // be current after the edge.
   function automatic logic led_value(input led_mode_e              m,
                                      input logic [LED_DUTY_MAXW-1:0] duty,
                                      input logic                   b,
                                      input logic [PWMW-1:0]        ph);
      logic v;
      v = 1'b0;
      case (m)
         LED_OFF:   v = 1'b0;
         LED_ON:    v = 1'b1;
         LED_BLINK: v = b;
         LED_PWM:   v = (LED_DUTY_MAXW'(ph) < duty);
         default:   v = 1'b0;
      endcase
      return v;
   endfunction

   // Next-state terms for the free-running prescaler, blink flop and PWM phase.
   always_comb begin
      // NOTE: every combinational output gets a value before any branch, so no
      // path can leave one unassigned and infer a latch.
      term      = term_of(cfg.div);
      wrap      = (cnt == term);
      blink_nxt = wrap ? ~blink : blink;
      phase_nxt = wrap ? phase + PWMW'(1) : phase;
      led_nxt   = led_value(cfg.mode, cfg.duty, blink_nxt, phase_nxt);
   end

   // Channel state. Reset beats load, and load beats the prescaler wrap.
   always_ff @(posedge clk100) begin
      // NOTE: state flops use non-blocking assignment so every flop samples
      // the pre-edge values, whatever order the statements appear in.
      if (rst) begin
         cfg   <= RST_CFG;
         cnt   <= '0;
         phase <= '0;
         blink <= 1'b0;
         led   <= 1'b0;
         tick  <= 1'b0;
      end else if (load) begin
         cfg   <= cfg_in;
         cnt   <= '0;
         phase <= '0;
         blink <= 1'b0;
         led   <= led_value(cfg_in.mode, cfg_in.duty, 1'b0, '0);
         tick  <= 1'b0;
      end else begin
         cnt   <= wrap ? '0 : cnt + CNTW'(1);
         phase <= phase_nxt;
         blink <= blink_nxt;
         led   <= led_nxt;
         tick  <= wrap;
      end
   end

endmodule

// File: rtl/led_ctrl_mc.sv
// Multi-channel programmable LED driver: write decode, error pulse, channel array.
module led_ctrl_mc
   import led_pkg::*;
#(
   parameter int        NCH      = 2,
   parameter int        DIVW     = 5,
   parameter int        CNTW     = 32,
   parameter int        PWMW     = 8,
   parameter led_mode_e RST_MODE = LED_RST_MODE,
   parameter int        RST_DIV  = LED_RST_DIV
)(
   input  logic              clk100,
   input  logic              rst,
   input  logic              wr_en_i,
   input  logic [3:0]        wr_ch_i,
   input  logic [1:0]        wr_mode_i,
   input  logic [DIVW-1:0]   wr_div_i,
   input  logic [PWMW-1:0]   wr_duty_i,
   output logic [NCH-1:0]    led_o,
   output logic [NCH-1:0]    tick_o,
   output logic              wr_err_o
);

   led_cfg_t          wr_cfg;
   logic [NCH-1:0]    load;
   logic              wr_bad;

   // Pack the write fields and decode the target channel.
   always_comb begin
      wr_cfg.mode = led_mode_e'(wr_mode_i);
      wr_cfg.div  = LED_DIV_MAXW'(wr_div_i);
      wr_cfg.duty = LED_DUTY_MAXW'(wr_duty_i);
      wr_bad      = wr_en_i && (int'(wr_ch_i) >= NCH);
      for (int i = 0; i < NCH; i++) begin
         load[i] = wr_en_i && (int'(wr_ch_i) == i);
      end
   end

   // One-cycle error pulse for a write aimed at a channel that does not exist.
   always_ff @(posedge clk100) begin
      if (rst) wr_err_o <= 1'b0;
      else     wr_err_o <= wr_bad;
   end

   for (genvar g = 0; g < NCH; g++) begin : g_chan
      led_chan #(
         .CNTW     (CNTW),
         .PWMW     (PWMW),
         .RST_MODE (RST_MODE),
         .RST_DIV  (RST_DIV)
      ) u_chan (
         .clk100 (clk100),
         .rst    (rst),
         .load   (load[g]),
         .cfg_in (wr_cfg),
         .led    (led_o[g]),
         .tick   (tick_o[g])
      );
   end

endmodule

// File: tb/tb_led_ctrl_mc.sv
// Self-checking bench for led_ctrl_mc: directed scenarios plus randomized
// traffic compared every cycle against a per-channel age-based model.
module tb_led_ctrl_mc;
   import led_pkg::*;

   localparam int NCH    = 2;
   localparam int DIVW   = 5;
   localparam int CNTW   = 6;
   localparam int PWMW   = 8;
   localparam int R_MODE = 2;   // BLINK
   localparam int R_DIV  = 2;

   logic              clk100 = 1'b0;
   logic              rst;
   logic              wr_en_i;
   logic [3:0]        wr_ch_i;
   logic [1:0]        wr_mode_i;
   logic [DIVW-1:0]   wr_div_i;
   logic [PWMW-1:0]   wr_duty_i;
   logic [NCH-1:0]    led_o;
   logic [NCH-1:0]    tick_o;
   logic              wr_err_o;

   int n_tests = 0;
   int n_fail  = 0;

   led_ctrl_mc #(
      .NCH      (NCH),
      .DIVW     (DIVW),
      .CNTW     (CNTW),
      .PWMW     (PWMW),
      .RST_MODE (LED_BLINK),
      .RST_DIV  (R_DIV)
   ) dut (
      .clk100    (clk100),
      .rst       (rst),
      .wr_en_i   (wr_en_i),
      .wr_ch_i   (wr_ch_i),
      .wr_mode_i (wr_mode_i),
      .wr_div_i  (wr_div_i),
      .wr_duty_i (wr_duty_i),
      .led_o     (led_o),
      .tick_o    (tick_o),
      .wr_err_o  (wr_err_o)
   );

   always #5 clk100 = ~clk100;

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Each channel is described by its config and its age: the number of
   // clock edges since its last reset or write. With period P = 2**min(d,CNTW-1)
   // the outputs follow directly: wraps = age/P, tick when age is a nonzero
   // multiple of P, blink = wraps odd, PWM lit when (wraps mod 2**PWMW) < duty.
   int     m_mode [NCH];
   int     m_div  [NCH];
   int     m_duty [NCH];
   longint m_age  [NCH];
   bit     m_fresh[NCH];
   bit     m_err;
   bit     model_valid = 1'b0;

   function automatic longint period(int ch);
      int e;
      e = m_div[ch];
      if (e > CNTW - 1) e = CNTW - 1;
      return longint'(1) << e;
   endfunction

   function automatic bit exp_led(int ch);
      longint w;
      if (m_fresh[ch]) return 1'b0;
      w = m_age[ch] / period(ch);
      case (m_mode[ch])
         1:       return 1'b1;
         2:       return (w % 2) == 1;
         3:       return (w % (longint'(1) << PWMW)) < m_duty[ch];
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit exp_tick(int ch);
      return (m_age[ch] > 0) && ((m_age[ch] % period(ch)) == 0);
   endfunction

   always @(posedge clk100) begin
      if (rst) begin
         for (int c = 0; c < NCH; c++) begin
            m_mode[c] = R_MODE; m_div[c] = R_DIV; m_duty[c] = 0;
            m_age[c] = 0; m_fresh[c] = 1'b1;
         end
         m_err = 1'b0;
         model_valid = 1'b1;
      end else if (model_valid) begin
         m_err = wr_en_i && (int'(wr_ch_i) >= NCH);
         for (int c = 0; c < NCH; c++) begin
            if (wr_en_i && int'(wr_ch_i) == c) begin
               m_mode[c] = int'(wr_mode_i); m_div[c] = int'(wr_div_i);
               m_duty[c] = int'(wr_duty_i); m_age[c] = 0;
            end else begin
               m_age[c]++;
            end
            m_fresh[c] = 1'b0;
         end
      end
   end

   // Compare all outputs against the model on every falling edge.
   always @(negedge clk100) begin
      logic [NCH-1:0] el, et;
      if (model_valid) begin
         for (int c = 0; c < NCH; c++) begin
            el[c] = exp_led(c);
            et[c] = exp_tick(c);
         end
         check("model_led_o", longint'(led_o), longint'(el));
         check("model_tick_o", longint'(tick_o), longint'(et));
         check("model_wr_err_o", longint'(wr_err_o), longint'(m_err));
      end
   end

   // ---------------- stimulus ----------------
   // Called at a falling edge; presents a write for one rising edge and
   // returns at the following falling edge.
   task automatic wr(input int ch, input int mode, input int div, input int duty);
      wr_en_i   = 1'b1;
      wr_ch_i   = 4'(ch);
      wr_mode_i = 2'(mode);
      wr_div_i  = DIVW'(div);
      wr_duty_i = PWMW'(duty);
      @(negedge clk100);
      wr_en_i = 1'b0;
   endtask

   initial begin
      int hi, lo, first_low;
      rst = 1'b1; wr_en_i = 1'b0; wr_ch_i = '0; wr_mode_i = '0;
      wr_div_i = '0; wr_duty_i = '0;
      repeat (3) @(negedge clk100);
      check("rst_led_o", longint'(led_o), 0);
      check("rst_tick_o", longint'(tick_o), 0);
      check("rst_wr_err_o", longint'(wr_err_o), 0);

      // Reset config BLINK with d=2: led rises after 4 edges, falls 4 later.
      rst = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk100);
         check("blink_rst_led0", longint'(led_o[0]), (k >= 4 && k < 8) ? 1 : 0);
         check("blink_rst_tick0", longint'(tick_o[0]), (k % 4 == 0) ? 1 : 0);
      end

      // PWM d=0 duty=64: 64 lit cycles then 192 dark.
      wr(1, 3, 0, 64);
      hi = 0; first_low = -1;
      for (int i = 0; i < 256; i++) begin
         if (led_o[1]) hi++;
         else if (first_low < 0) first_low = i;
         @(negedge clk100);
      end
      check("pwm64_high_count", hi, 64);
      check("pwm64_first_low", first_low, 64);

      // duty=255: dark exactly once per 256-cycle frame.
      wr(1, 3, 0, 255);
      lo = 0;
      for (int i = 0; i < 512; i++) begin
         if (!led_o[1]) lo++;
         @(negedge clk100);
      end
      check("pwm255_low_count", lo, 2);

      // duty=0: never lit.
      wr(1, 3, 0, 0);
      hi = 0;
      for (int i = 0; i < 512; i++) begin
         if (led_o[1]) hi++;
         @(negedge clk100);
      end
      check("pwm0_high_count", hi, 0);

      // Write to a channel that does not exist.
      wr(5, 1, 0, 0);
      check("err_pulse_hi", longint'(wr_err_o), 1);
      @(negedge clk100);
      check("err_pulse_lo", longint'(wr_err_o), 0);

      // Rewrite ch0 on the exact cycle its counter sits at terminal.
      wr(0, 2, 2, 0);
      repeat (3) @(negedge clk100);
      wr(0, 2, 3, 0);
      check("wrapwr_tick0", longint'(tick_o[0]), 0);
      check("wrapwr_led0", longint'(led_o[0]), 0);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk100);
         check("wrapwr_led0_seq", longint'(led_o[0]), (k == 8) ? 1 : 0);
      end
      check("wrapwr_tick0_8", longint'(tick_o[0]), 1);

      // Reset mid-PWM with a concurrent write: reset wins, write discarded.
      wr(0, 3, 0, 200);
      repeat (10) @(negedge clk100);
      rst = 1'b1; wr_en_i = 1'b1; wr_ch_i = 4'd0; wr_mode_i = 2'd1;
      @(negedge clk100);
      check("rstwr_led_o", longint'(led_o), 0);
      check("rstwr_tick_o", longint'(tick_o), 0);
      rst = 1'b0; wr_en_i = 1'b0;
      repeat (4) @(negedge clk100);
      check("rstwr_blink_led", longint'(led_o), 3);
      check("rstwr_blink_tick", longint'(tick_o), 3);

      // Randomized traffic, checked every cycle by the model.
      for (int i = 0; i < 4000; i++) begin
         rst       = ($urandom_range(0, 399) == 0);
         wr_en_i   = ($urandom_range(0, 5) == 0);
         wr_ch_i   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                 : 4'($urandom_range(0, 2));
         wr_mode_i = 2'($urandom_range(0, 3));
         wr_div_i  = ($urandom_range(0, 7) == 0) ? DIVW'($urandom_range(0, 31))
                                                 : DIVW'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0:       wr_duty_i = '0;
            1:       wr_duty_i = '1;
            default: wr_duty_i = PWMW'($urandom_range(0, 255));
         endcase
         @(negedge clk100);
      end
      rst = 1'b0; wr_en_i = 1'b0;
      repeat (4) @(negedge clk100);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
